// File: rtl/cpu_pkg.sv
// Shared pipeline types: writeback-select and load-type encodings plus the MEM/WB latch bundle.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WDSEL_ALU = 2'd0;
  localparam logic [1:0] WDSEL_MEM = 2'd1;
  localparam logic [1:0] WDSEL_PC4 = 2'd2;

  localparam logic [2:0] DM_LW  = 3'd0;
  localparam logic [2:0] DM_LH  = 3'd1;
  localparam logic [2:0] DM_LHU = 3'd2;
  localparam logic [2:0] DM_LB  = 3'd3;
  localparam logic [2:0] DM_LBU = 3'd4;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic [4:0]      rd;
    logic [1:0]      wdsel;
    logic [2:0]      dmtype;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] pc;
  } mem_wb_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load alignment: picks the byte/halfword addressed by off out of the raw word and extends it.
// Purely combinational, zero latency, no flow control.
module load_align
  import cpu_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [2:0]        dmtype,
  output logic [DATA_W-1:0] data
);

  logic [15:0] half;
  logic [7:0]  bval;

  always_comb begin
    half = off[1] ? rdata[31:16] : rdata[15:0];
    bval = rdata[7:0];
    case (off)
      2'd1:    bval = rdata[15:8];
      2'd2:    bval = rdata[23:16];
      2'd3:    bval = rdata[31:24];
      default: bval = rdata[7:0];
    endcase

    // Unknown load types fall back to a full-word load.
    data = rdata;
    case (dmtype)
      DM_LH:   data = {{(DATA_W-16){half[15]}}, half};
      DM_LHU:  data = {{(DATA_W-16){1'b0}}, half};
      DM_LB:   data = {{(DATA_W-8){bval[7]}}, bval};
      DM_LBU:  data = {{(DATA_W-8){1'b0}}, bval};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB latch, load extension, result select, single-cycle RF write and retire count.
// One cycle latency (captured at edge N, committed at N+1); stall holds the latch but side effects fire once.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [4:0]        mem_rd,
  input  logic [1:0]        mem_wdsel,
  input  logic [2:0]        mem_dmtype,
  input  logic [DATA_W-1:0] mem_alu_out,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] mem_pc,
  output logic              rf_wr,
  output logic [4:0]        rf_a3,
  output logic [DATA_W-1:0] rf_wd,
  output logic              wb_fwd_valid,
  output logic [4:0]        wb_fwd_rd,
  output logic [DATA_W-1:0] wb_fwd_data,
  output logic              retire_pulse,
  output logic [CNT_W-1:0]  retire_cnt
);

  mem_wb_t           lat;
  mem_wb_t           in_b;
  logic              done;
  logic              fire;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] wd;

  assign in_b = '{valid:     mem_valid,
                  reg_write: mem_reg_write,
                  rd:        mem_rd,
                  wdsel:     mem_wdsel,
                  dmtype:    mem_dmtype,
                  alu_out:   mem_alu_out,
                  rdata:     mem_rdata,
                  pc:        mem_pc};

  // done marks a stalled instruction whose side effects already happened.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat  <= '0;
      done <= 1'b0;
    end else if (flush) begin
      lat.valid <= 1'b0;
      done      <= 1'b0;
    end else if (stall) begin
      done <= lat.valid;
    end else begin
      lat  <= in_b;
      done <= 1'b0;
    end
  end

  assign fire = lat.valid & ~done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt <= '0;
    end else if (fire) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata  (lat.rdata),
    .off    (lat.alu_out[1:0]),
    .dmtype (lat.dmtype),
    .data   (ld_data)
  );

  always_comb begin
    wd = '0;
    case (lat.wdsel)
      WDSEL_ALU: wd = lat.alu_out;
      WDSEL_MEM: wd = ld_data;
      WDSEL_PC4: wd = lat.pc + DATA_W'(4);
      default:   wd = '0;
    endcase
  end

  assign rf_wr        = fire & lat.reg_write & (lat.rd != 5'd0);
  assign rf_a3        = lat.rd;
  assign rf_wd        = wd;
  assign wb_fwd_valid = lat.valid & lat.reg_write & (lat.rd != 5'd0);
  assign wb_fwd_rd    = lat.rd;
  assign wb_fwd_data  = wd;
  assign retire_pulse = fire;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for the datapath, hand sequences for stall/flush/reset.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wdsel;
  logic [2:0]  mem_dmtype;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_rdata;
  logic [31:0] mem_pc;
  logic        rf_wr;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        retire_pulse;
  logic [31:0] retire_cnt;

  int n_cmp = 0;
  int n_err = 0;

  wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_wdsel     (mem_wdsel),
    .mem_dmtype    (mem_dmtype),
    .mem_alu_out   (mem_alu_out),
    .mem_rdata     (mem_rdata),
    .mem_pc        (mem_pc),
    .rf_wr         (rf_wr),
    .rf_a3         (rf_a3),
    .rf_wd         (rf_wd),
    .wb_fwd_valid  (wb_fwd_valid),
    .wb_fwd_rd     (wb_fwd_rd),
    .wb_fwd_data   (wb_fwd_data),
    .retire_pulse  (retire_pulse),
    .retire_cnt    (retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  wdsel;
    logic [2:0]  dmtype;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] alu_out;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic        exp_wr;
    logic        exp_fwd;
    logic [31:0] exp_wd;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  function automatic vec_t mk(logic [1:0] wdsel, logic [2:0] dmtype, logic [4:0] rd,
                              logic reg_write, logic [31:0] alu_out, logic [31:0] rdata,
                              logic [31:0] pc, logic exp_wr, logic exp_fwd, logic [31:0] exp_wd);
    vec_t v;
    v.wdsel = wdsel; v.dmtype = dmtype; v.rd = rd; v.reg_write = reg_write;
    v.alu_out = alu_out; v.rdata = rdata; v.pc = pc;
    v.exp_wr = exp_wr; v.exp_fwd = exp_fwd; v.exp_wd = exp_wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [1:0] wdsel, input logic [2:0] dmtype,
                       input logic [4:0] rd, input logic reg_write, input logic [31:0] alu_out,
                       input logic [31:0] rdata, input logic [31:0] pc);
    mem_valid = valid; mem_wdsel = wdsel; mem_dmtype = dmtype; mem_rd = rd;
    mem_reg_write = reg_write; mem_alu_out = alu_out; mem_rdata = rdata; mem_pc = pc;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int base;

    vecs[0]  = mk(2'd0, 3'd0, 5'd5,  1'b1, 32'h1234_5678, 32'h0,         32'h100,       1'b1, 1'b1, 32'h1234_5678);
    vecs[1]  = mk(2'd1, 3'd3, 5'd6,  1'b1, 32'h0000_0003, 32'h80FF_7F01, 32'h104,       1'b1, 1'b1, 32'hFFFF_FF80);
    vecs[2]  = mk(2'd1, 3'd4, 5'd6,  1'b1, 32'h0000_0001, 32'h80FF_7F01, 32'h108,       1'b1, 1'b1, 32'h0000_007F);
    vecs[3]  = mk(2'd1, 3'd1, 5'd8,  1'b1, 32'h0000_0002, 32'h80FF_7F01, 32'h10C,       1'b1, 1'b1, 32'hFFFF_80FF);
    vecs[4]  = mk(2'd1, 3'd2, 5'd8,  1'b1, 32'h0000_0000, 32'h80FF_7F01, 32'h110,       1'b1, 1'b1, 32'h0000_7F01);
    vecs[5]  = mk(2'd1, 3'd0, 5'd9,  1'b1, 32'h0000_0002, 32'h80FF_7F01, 32'h114,       1'b1, 1'b1, 32'h80FF_7F01);
    vecs[6]  = mk(2'd2, 3'd0, 5'd1,  1'b1, 32'h0,         32'h0,         32'h0000_0040, 1'b1, 1'b1, 32'h0000_0044);
    vecs[7]  = mk(2'd2, 3'd0, 5'd1,  1'b1, 32'h0,         32'h0,         32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0000);
    vecs[8]  = mk(2'd0, 3'd0, 5'd0,  1'b1, 32'h0000_DEAD, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_DEAD);
    vecs[9]  = mk(2'd0, 3'd0, 5'd9,  1'b0, 32'h0000_BEEF, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_BEEF);
    vecs[10] = mk(2'd3, 3'd0, 5'd10, 1'b1, 32'h0000_5555, 32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_0000);
    vecs[11] = mk(2'd1, 3'd7, 5'd11, 1'b1, 32'h0000_0001, 32'h80FF_7F01, 32'h0,         1'b1, 1'b1, 32'h80FF_7F01);
    vecs[12] = mk(2'd1, 3'd1, 5'd11, 1'b1, 32'h0000_0003, 32'h80FF_7F01, 32'h0,         1'b1, 1'b1, 32'hFFFF_80FF);
    vecs[13] = mk(2'd1, 3'd3, 5'd12, 1'b1, 32'h0000_0000, 32'h80FF_7F01, 32'h0,         1'b1, 1'b1, 32'h0000_0001);
    vecs[14] = mk(2'd1, 3'd4, 5'd12, 1'b1, 32'h0000_0002, 32'h80FF_7F01, 32'h0,         1'b1, 1'b1, 32'h0000_00FF);

    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("reset rf_wr", {31'b0, rf_wr}, 32'h0);
    chk("reset rf_a3", {27'b0, rf_a3}, 32'h0);
    chk("reset rf_wd", rf_wd, 32'h0);
    chk("reset fwd_valid", {31'b0, wb_fwd_valid}, 32'h0);
    chk("reset retire_pulse", {31'b0, retire_pulse}, 32'h0);
    chk("reset retire_cnt", retire_cnt, 32'h0);
    rst = 1'b1;

    // Back-to-back vectors: each fires in the cycle after capture, counter lags by one edge.
    for (int i = 0; i < NVEC; i++) begin
      drive(1'b1, vecs[i].wdsel, vecs[i].dmtype, vecs[i].rd, vecs[i].reg_write,
            vecs[i].alu_out, vecs[i].rdata, vecs[i].pc);
      step();
      chk($sformatf("vec%0d rf_wr", i), {31'b0, rf_wr}, {31'b0, vecs[i].exp_wr});
      chk($sformatf("vec%0d rf_a3", i), {27'b0, rf_a3}, {27'b0, vecs[i].rd});
      chk($sformatf("vec%0d rf_wd", i), rf_wd, vecs[i].exp_wd);
      chk($sformatf("vec%0d fwd_valid", i), {31'b0, wb_fwd_valid}, {31'b0, vecs[i].exp_fwd});
      chk($sformatf("vec%0d fwd_rd", i), {27'b0, wb_fwd_rd}, {27'b0, vecs[i].rd});
      chk($sformatf("vec%0d fwd_data", i), wb_fwd_data, vecs[i].exp_wd);
      chk($sformatf("vec%0d retire_pulse", i), {31'b0, retire_pulse}, 32'h1);
      chk($sformatf("vec%0d retire_cnt", i), retire_cnt, i);
    end
    drive(1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    chk("bubble rf_wr", {31'b0, rf_wr}, 32'h0);
    chk("bubble retire_pulse", {31'b0, retire_pulse}, 32'h0);
    chk("after vectors retire_cnt", retire_cnt, NVEC);
    base = NVEC;

    // Stall: write fires once, forwarding stays live for all held cycles.
    drive(1'b1, 2'd0, 3'd0, 5'd7, 1'b1, 32'h0000_0777, 32'h0, 32'h0);
    step();
    chk("stall c0 rf_wr", {31'b0, rf_wr}, 32'h1);
    chk("stall c0 fwd_valid", {31'b0, wb_fwd_valid}, 32'h1);
    chk("stall c0 rf_wd", rf_wd, 32'h0000_0777);
    stall = 1'b1;
    drive(1'b1, 2'd0, 3'd0, 5'd3, 1'b1, 32'h0000_0333, 32'h0, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk($sformatf("stall c%0d rf_wr", c), {31'b0, rf_wr}, 32'h0);
      chk($sformatf("stall c%0d retire_pulse", c), {31'b0, retire_pulse}, 32'h0);
      chk($sformatf("stall c%0d fwd_valid", c), {31'b0, wb_fwd_valid}, 32'h1);
      chk($sformatf("stall c%0d fwd_rd", c), {27'b0, wb_fwd_rd}, 32'd7);
      chk($sformatf("stall c%0d fwd_data", c), wb_fwd_data, 32'h0000_0777);
      chk($sformatf("stall c%0d retire_cnt", c), retire_cnt, base + 1);
    end
    flush = 1'b1;
    step();
    chk("flush+stall rf_wr", {31'b0, rf_wr}, 32'h0);
    chk("flush+stall fwd_valid", {31'b0, wb_fwd_valid}, 32'h0);
    chk("flush+stall retire_pulse", {31'b0, retire_pulse}, 32'h0);
    chk("flush+stall retire_cnt", retire_cnt, base + 1);
    flush = 1'b0; stall = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    chk("post flush retire_cnt", retire_cnt, base + 1);

    // Asynchronous reset while a write is pending.
    drive(1'b1, 2'd0, 3'd0, 5'd12, 1'b1, 32'hCAFE_F00D, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    chk("pre-reset rf_wr", {31'b0, rf_wr}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("async reset rf_wr", {31'b0, rf_wr}, 32'h0);
    chk("async reset rf_a3", {27'b0, rf_a3}, 32'h0);
    chk("async reset rf_wd", rf_wd, 32'h0);
    chk("async reset fwd_valid", {31'b0, wb_fwd_valid}, 32'h0);
    chk("async reset retire_cnt", retire_cnt, 32'h0);
    drive(1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("post reset c%0d rf_wr", c), {31'b0, rf_wr}, 32'h0);
      chk($sformatf("post reset c%0d retire_cnt", c), retire_cnt, 32'h0);
    end
    drive(1'b1, 2'd0, 3'd0, 5'd13, 1'b1, 32'h0000_1313, 32'h0, 32'h0);
    step();
    chk("restart rf_wr", {31'b0, rf_wr}, 32'h1);
    chk("restart rf_a3", {27'b0, rf_a3}, 32'd13);
    drive(1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    chk("restart retire_cnt", retire_cnt, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
